// File: rtl/fm_phase_discriminator.sv
// FM discriminator: frequency is the wrapped phase step between consecutive CORDIC beats,
// with squelch, boxcar decimation, arithmetic scaling and output saturation.
module fm_phase_discriminator #(
  parameter int ANGLE_WIDTH            = 16,
  parameter int OUT_WIDTH              = 16,
  parameter int DECIM                  = 1,
  parameter int SHIFT                  = 0,
  parameter int MAG_THRESH             = 0,
  parameter int c_s00_axis_tdata_width = 32,
  parameter int c_m00_axis_tdata_width = 32
) (
  input  logic                                  s00_axis_aclk,
  input  logic                                  s00_axis_aresetn,
  input  logic                                  s00_axis_tvalid,
  input  logic                                  s00_axis_tlast,
  input  logic [c_s00_axis_tdata_width-1:0]     s00_axis_tdata,
  input  logic [(c_s00_axis_tdata_width/8)-1:0] s00_axis_tstrb,
  output logic                                  s00_axis_tready,
  input  logic                                  m00_axis_tready,
  output logic                                  m00_axis_tvalid,
  output logic                                  m00_axis_tlast,
  output logic [c_m00_axis_tdata_width-1:0]     m00_axis_tdata,
  output logic [(c_m00_axis_tdata_width/8)-1:0] m00_axis_tstrb
);

  localparam int ACC_W = ANGLE_WIDTH + $clog2(DECIM) + 1;
  localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [15:0]        MAG_T  = MAG_THRESH[15:0];
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DECIM - 1);
  localparam logic signed [63:0] MAX_V  = (64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1;
  localparam logic signed [63:0] MIN_V  = -(64'sd1 <<< (OUT_WIDTH - 1));

  logic [ANGLE_WIDTH-1:0]              r_angle;
  logic                                r_primed;
  logic signed [ACC_W-1:0]             r_acc;
  logic [CNT_W-1:0]                    r_cnt;
  logic                                r_tvalid;
  logic                                r_tlast;
  logic [c_m00_axis_tdata_width-1:0]   r_tdata;

  logic [ANGLE_WIDTH-1:0]  w_angle;
  logic [15:0]             w_mag;
  logic [ANGLE_WIDTH-1:0]  w_diff;
  logic [ANGLE_WIDTH-1:0]  w_d;
  logic                    w_squelch;
  logic                    w_accept;
  logic                    w_emit;
  logic signed [ACC_W-1:0] w_d_ext;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] w_shifted;
  logic signed [63:0]      w_wide;
  logic signed [63:0]      w_sat;
  logic                    w_unused;

  assign w_unused = ^{s00_axis_tstrb, s00_axis_tdata};

  assign s00_axis_tready = m00_axis_tready | ~r_tvalid;
  assign w_accept        = s00_axis_tvalid & s00_axis_tready;

  assign w_angle   = s00_axis_tdata[16 +: ANGLE_WIDTH];
  assign w_mag     = s00_axis_tdata[15:0];
  // Modular subtraction gives the shortest-path step across the +/-pi seam.
  assign w_diff    = w_angle - r_angle;
  assign w_squelch = (MAG_THRESH != 0) && (w_mag < MAG_T);
  assign w_d       = (r_primed && !w_squelch) ? w_diff : '0;
  assign w_d_ext   = {{(ACC_W - ANGLE_WIDTH){w_d[ANGLE_WIDTH-1]}}, w_d};
  assign w_sum     = r_acc + w_d_ext;
  assign w_emit    = (DECIM == 1) || (r_cnt == CNT_LAST) || s00_axis_tlast;

  assign w_shifted = w_sum >>> SHIFT;
  assign w_wide    = {{(64 - ACC_W){w_shifted[ACC_W-1]}}, w_shifted};

  always_comb begin
    w_sat = w_wide;
    if (w_wide > MAX_V)
      w_sat = MAX_V;
    else if (w_wide < MIN_V)
      w_sat = MIN_V;
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_aresetn) begin
      r_angle  <= '0;
      r_primed <= 1'b0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tdata  <= '0;
    end else begin
      if (w_accept) begin
        r_angle  <= w_angle;
        r_primed <= ~s00_axis_tlast;
        if (w_emit) begin
          r_acc <= '0;
          r_cnt <= '0;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + 1'b1;
        end
      end
      // A new emit takes priority over draining, so back-to-back outputs never bubble.
      if (w_accept && w_emit) begin
        r_tdata  <= w_sat[c_m00_axis_tdata_width-1:0];
        r_tvalid <= 1'b1;
        r_tlast  <= s00_axis_tlast;
      end else if (r_tvalid && m00_axis_tready) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign m00_axis_tvalid = r_tvalid;
  assign m00_axis_tlast  = r_tlast;
  assign m00_axis_tdata  = r_tdata;
  assign m00_axis_tstrb  = '1;

endmodule

// File: tb/tb_fm_phase_discriminator.sv
// Directed bench: four discriminator configurations share one input stream; each test
// resets all of them and checks the instance whose parameters it exercises.
module tb_fm_phase_discriminator;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic [31:0] s_tdata = '0;
  logic        m_tready = 1'b1;

  logic        a_s_tready, a_tvalid, a_tlast;
  logic [31:0] a_tdata;
  logic [3:0]  a_tstrb;
  logic        b_s_tready, b_tvalid, b_tlast;
  logic [31:0] b_tdata;
  logic [3:0]  b_tstrb;
  logic        c_s_tready, c_tvalid, c_tlast;
  logic [31:0] c_tdata;
  logic [3:0]  c_tstrb;
  logic        d_s_tready, d_tvalid, d_tlast;
  logic [31:0] d_tdata;
  logic [3:0]  d_tstrb;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fm_phase_discriminator dut_a (
    .s00_axis_aclk(clk), .s00_axis_aresetn(rst), .s00_axis_tvalid(s_tvalid),
    .s00_axis_tlast(s_tlast), .s00_axis_tdata(s_tdata), .s00_axis_tstrb(4'hF),
    .s00_axis_tready(a_s_tready), .m00_axis_tready(m_tready), .m00_axis_tvalid(a_tvalid),
    .m00_axis_tlast(a_tlast), .m00_axis_tdata(a_tdata), .m00_axis_tstrb(a_tstrb));

  fm_phase_discriminator #(.DECIM(4), .SHIFT(2)) dut_b (
    .s00_axis_aclk(clk), .s00_axis_aresetn(rst), .s00_axis_tvalid(s_tvalid),
    .s00_axis_tlast(s_tlast), .s00_axis_tdata(s_tdata), .s00_axis_tstrb(4'hF),
    .s00_axis_tready(b_s_tready), .m00_axis_tready(m_tready), .m00_axis_tvalid(b_tvalid),
    .m00_axis_tlast(b_tlast), .m00_axis_tdata(b_tdata), .m00_axis_tstrb(b_tstrb));

  fm_phase_discriminator #(.MAG_THRESH(16'h0100)) dut_c (
    .s00_axis_aclk(clk), .s00_axis_aresetn(rst), .s00_axis_tvalid(s_tvalid),
    .s00_axis_tlast(s_tlast), .s00_axis_tdata(s_tdata), .s00_axis_tstrb(4'hF),
    .s00_axis_tready(c_s_tready), .m00_axis_tready(m_tready), .m00_axis_tvalid(c_tvalid),
    .m00_axis_tlast(c_tlast), .m00_axis_tdata(c_tdata), .m00_axis_tstrb(c_tstrb));

  fm_phase_discriminator #(.OUT_WIDTH(8)) dut_d (
    .s00_axis_aclk(clk), .s00_axis_aresetn(rst), .s00_axis_tvalid(s_tvalid),
    .s00_axis_tlast(s_tlast), .s00_axis_tdata(s_tdata), .s00_axis_tstrb(4'hF),
    .s00_axis_tready(d_s_tready), .m00_axis_tready(m_tready), .m00_axis_tvalid(d_tvalid),
    .m00_axis_tlast(d_tlast), .m00_axis_tdata(d_tdata), .m00_axis_tstrb(d_tstrb));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %08h", tag, got);
    end
  endtask

  task automatic drive(input logic [15:0] ang, input logic [15:0] mag, input logic last);
    s_tdata  = {ang, mag};
    s_tvalid = 1'b1;
    s_tlast  = last;
  endtask

  // One accepted beat; returns on the following negedge with the result visible.
  task automatic beat(input logic [15:0] ang, input logic [15:0] mag, input logic last);
    @(negedge clk);
    drive(ang, mag, last);
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    check_eq("reset tvalid", {31'b0, a_tvalid}, 32'h0);
    check_eq("reset tdata", a_tdata, 32'h0);
    check_eq("reset tlast", {31'b0, a_tlast}, 32'h0);
    check_eq("reset s_tready", {31'b0, a_s_tready}, 32'h1);
    check_eq("tstrb", {28'b0, a_tstrb}, 32'hF);

    // Basic differences, DECIM=1
    beat(16'h1000, 16'h0000, 1'b0);
    check_eq("basic1 tvalid", {31'b0, a_tvalid}, 32'h1);
    check_eq("basic1 data", a_tdata, 32'h0000_0000);
    beat(16'h1800, 16'h0000, 1'b0);
    check_eq("basic2 data", a_tdata, 32'h0000_0800);
    beat(16'h1000, 16'h0000, 1'b0);
    check_eq("basic3 data", a_tdata, 32'hFFFF_F800);

    // Same beat with reset held asserted
    @(negedge clk);
    rst = 1'b1;
    drive(16'h1800, 16'h0000, 1'b0);
    @(negedge clk);
    s_tvalid = 1'b0;
    check_eq("rst held tvalid", {31'b0, a_tvalid}, 32'h0);
    check_eq("rst held tdata", a_tdata, 32'h0);
    rst = 1'b0;

    // Wrap across the seam
    do_reset();
    beat(16'hFF00, 16'h0000, 1'b0);
    beat(16'h0100, 16'h0000, 1'b0);
    check_eq("wrap pos", a_tdata, 32'h0000_0200);
    do_reset();
    beat(16'h0100, 16'h0000, 1'b0);
    beat(16'hFF00, 16'h0000, 1'b0);
    check_eq("wrap neg", a_tdata, 32'hFFFF_FE00);

    // Decimation by 4 with shift 2 and a short final block
    do_reset();
    beat(16'h0000, 16'h0000, 1'b0);
    check_eq("dec beat1 tvalid", {31'b0, b_tvalid}, 32'h0);
    beat(16'h0100, 16'h0000, 1'b0);
    beat(16'h0200, 16'h0000, 1'b0);
    beat(16'h0300, 16'h0000, 1'b0);
    check_eq("dec out1 tvalid", {31'b0, b_tvalid}, 32'h1);
    check_eq("dec out1 data", b_tdata, 32'h0000_00C0);
    check_eq("dec out1 tlast", {31'b0, b_tlast}, 32'h0);
    beat(16'h0400, 16'h0000, 1'b0);
    check_eq("dec beat5 tvalid", {31'b0, b_tvalid}, 32'h0);
    beat(16'h0500, 16'h0000, 1'b1);
    check_eq("dec out2 data", b_tdata, 32'h0000_0080);
    check_eq("dec out2 tlast", {31'b0, b_tlast}, 32'h1);
    beat(16'h0900, 16'h0000, 1'b1);
    check_eq("dec newpkt data", b_tdata, 32'h0000_0000);
    check_eq("dec newpkt tvalid", {31'b0, b_tvalid}, 32'h1);

    // Squelch at threshold 0x100
    do_reset();
    beat(16'h0000, 16'h0200, 1'b0);
    check_eq("sq prime", c_tdata, 32'h0);
    beat(16'h0400, 16'h00FF, 1'b0);
    check_eq("sq below", c_tdata, 32'h0);
    beat(16'h0800, 16'h0200, 1'b0);
    check_eq("sq above", c_tdata, 32'h0000_0400);
    beat(16'h0C00, 16'h0100, 1'b0);
    check_eq("sq equal", c_tdata, 32'h0000_0400);

    // Saturation at 8-bit output
    do_reset();
    beat(16'h0000, 16'h0000, 1'b0);
    beat(16'h0200, 16'h0000, 1'b0);
    check_eq("sat pos", d_tdata, 32'h0000_007F);
    beat(16'h0000, 16'h0000, 1'b0);
    check_eq("sat neg", d_tdata, 32'hFFFF_FF80);
    beat(16'h007F, 16'h0000, 1'b0);
    check_eq("sat max exact", d_tdata, 32'h0000_007F);
    beat(16'h0000, 16'h0000, 1'b0);
    check_eq("sat in range neg", d_tdata, 32'hFFFF_FF81);

    // Backpressure on the default instance
    do_reset();
    beat(16'h1000, 16'h0000, 1'b0);
    beat(16'h1100, 16'h0000, 1'b0);
    check_eq("bp first out", a_tdata, 32'h0000_0100);
    m_tready = 1'b0;
    drive(16'h1300, 16'h0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq($sformatf("bp stall%0d data", i), a_tdata, 32'h0000_0100);
      check_eq($sformatf("bp stall%0d s_tready", i), {31'b0, a_s_tready}, 32'h0);
      check_eq($sformatf("bp stall%0d tvalid", i), {31'b0, a_tvalid}, 32'h1);
    end
    m_tready = 1'b1;
    @(negedge clk);
    check_eq("bp release data", a_tdata, 32'h0000_0200);
    check_eq("bp release tvalid", {31'b0, a_tvalid}, 32'h1);
    drive(16'h1600, 16'h0000, 1'b0);
    @(negedge clk);
    check_eq("b2b 1 data", a_tdata, 32'h0000_0300);
    check_eq("b2b 1 tvalid", {31'b0, a_tvalid}, 32'h1);
    drive(16'h1A00, 16'h0000, 1'b0);
    @(negedge clk);
    check_eq("b2b 2 data", a_tdata, 32'h0000_0400);
    check_eq("b2b 2 tvalid", {31'b0, a_tvalid}, 32'h1);
    m_tready = 1'b0;
    s_tvalid = 1'b0;
    @(negedge clk);
    check_eq("stall2 data", a_tdata, 32'h0000_0400);
    check_eq("stall2 tvalid", {31'b0, a_tvalid}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midstall rst tvalid", {31'b0, a_tvalid}, 32'h0);
    check_eq("midstall rst tdata", a_tdata, 32'h0);
    rst      = 1'b0;
    m_tready = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
